banked_regfile: RTL and testbench
=================================

# banked_regfile

Parametrised successor to the CPU general register file: DATA_W-bit registers, READ_PORTS combinational read ports, and NUM_BANKS copies of the low eight registers. The bank switches in hardware on interrupt entry and exit, so the ISR needs no save/restore code. The block also provides a hardware-managed stack pointer with increment/decrement strobes and optional write-to-read bypass. It sits between decode and the ALU in the core; SR and PC are owned elsewhere and only mirrored here as read-only sources.

## Interface
- DATA_W, 16, register width in bits
- NUM_BANKS, 2, copies of r0–r7; legal range ≥1; interrupt nesting depth is NUM_BANKS-1
- READ_PORTS, 3, number of independent read ports
- SP_RESET, 16'hBFFF, reset value of SP (truncated/zero-extended to DATA_W)
- SP_STRIDE, 1, amount added/subtracted by sp_inc/sp_dec
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low
- read_addr  in  4*READ_PORTS  port i address at [4i+3:4i]
- read_data  out  DATA_W*READ_PORTS  port i data at [DATA_W*i +: DATA_W], combinational
- write_addr  in  4  write address
- write_data  in  DATA_W  write data
- write_en  in  1  commit write at next rising edge
- sp_inc, sp_dec  in  1  SP ± SP_STRIDE at next edge
- irq_enter  in  1  one-cycle pulse: switch to next bank
- irq_exit  in  1  one-cycle pulse: return to previous bank
- SR, PC  in  DATA_W  read-only sources for addresses E, F
- sp  out  DATA_W  current SP, registered
- active_bank  out  $clog2(NUM_BANKS) (min 1)  current bank, registered
- bank_overflow  out  1  sticky: irq_enter at top bank
- bank_underflow  out  1  sticky: irq_exit at bank 0
- flag_clear  in  1  clears both sticky flags

## Operation
- Address map: 0–7 banked[active_bank][a]; 8–B scratch (shared across banks); C ISR; D SP; E SR input; F PC input.
- Writes to E/F are silently dropped. All other writes land in the target register at the edge when write_en=1.
- Banked writes target the bank active in the write cycle, even if a bank switch commits at the same edge.
- SP priority, highest first:
  1. write_en with address D
  2. sp_inc and sp_dec both high: no change
  3. sp_inc
  4. sp_dec
- SP arithmetic is modulo 2^DATA_W; wrap is silent.
- Bank control (active_bank = 0 after reset):
  - irq_enter with active_bank < NUM_BANKS-1: active_bank+1.
  - irq_enter at the top bank: bank unchanged, bank_overflow set.
  - irq_exit with active_bank > 0: active_bank-1.
  - irq_exit at bank 0: bank unchanged, bank_underflow set.
  - irq_enter and irq_exit together: no change, no flag.
  - NUM_BANKS=1: every enter/exit is an overflow/underflow respectively.
- Sticky flags: flag_clear has priority over a set in the same cycle.
- Bypass (BYPASS=1): when write_en=1 and a port's read_addr equals write_addr (not E/F), read_data = write_data. For address D, this holds only when the write wins SP priority. With BYPASS=0, reads return pre-edge contents.
- Reset state: all banked, scratch and ISR registers 0; SP = SP_RESET; active_bank 0; both flags 0. Reset is effective immediately and asynchronously, including mid-interrupt.

## Timing
- Reads: zero latency, combinational from addresses, register state, SR and PC.
- Writes, SP updates, bank switches and flags: visible on read_data/outputs in the cycle after the edge.
- A read of a banked register in the cycle after irq_enter sees the new bank.
- No handshake; every strobe is accepted each cycle.

## Test plan
- Reset: deassert reset → sp=BFFF, active_bank=0, flags 0; reading 0..C returns 0; E/F return the SR/PC inputs.
- Bank isolation: write r3=1111 in bank 0, pulse irq_enter, write r3=2222 and r9=5555 → bank 1 reads r3=2222; after irq_exit, r3=1111 and r9=5555.
- Overflow/underflow (NUM_BANKS=2):
  - enter, enter → bank 1, bank_overflow=1.
  - exit, exit → bank 0, bank_underflow=1.
  - flag_clear → both flags 0.
- SP priority:
  - sp_dec ×3 from BFFF → BFFC.
  - write D=0000 with sp_inc in the same cycle → 0000.
  - sp_dec at 0000 → FFFF.
- Bypass: BYPASS=1, write r5=ABCD while port 2 reads r5 → ABCD in the same cycle. BYPASS=0 → old value; ABCD appears the next cycle.
- Async reset mid-ISR: bank 1 active, SP=1234; assert reset between edges → active_bank=0 and sp=BFFF immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/banked_regfile.sv
// General register file with per-interrupt-level banks of r0-r7, shared scratch/ISR registers,
// a hardware-managed stack pointer and optional same-cycle write-to-read forwarding.
module banked_regfile #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned NUM_BANKS  = 2,
  parameter int unsigned READ_PORTS = 3,
  parameter int unsigned SP_RESET   = 32'hBFFF,
  parameter int unsigned SP_STRIDE  = 1,
  parameter bit          BYPASS     = 1'b1,
  localparam int unsigned BankW     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [4*READ_PORTS-1:0]      read_addr,
  output logic [DATA_W*READ_PORTS-1:0] read_data,
  input  logic [3:0]                   write_addr,
  input  logic [DATA_W-1:0]            write_data,
  input  logic                         write_en,
  input  logic                         sp_inc,
  input  logic                         sp_dec,
  input  logic                         irq_enter,
  input  logic                         irq_exit,
  input  logic [DATA_W-1:0]            SR,
  input  logic [DATA_W-1:0]            PC,
  output logic [DATA_W-1:0]            sp,
  output logic [BankW-1:0]             active_bank,
  output logic                         bank_overflow,
  output logic                         bank_underflow,
  input  logic                         flag_clear
);

  localparam logic [DATA_W-1:0] SpReset  = DATA_W'(SP_RESET);
  localparam logic [DATA_W-1:0] SpStride = DATA_W'(SP_STRIDE);
  localparam logic [BankW-1:0]  TopBank  = BankW'(NUM_BANKS - 1);

  logic [DATA_W-1:0] gpr_q [NUM_BANKS][8];
  logic [DATA_W-1:0] scratch_q [4];
  logic [DATA_W-1:0] isr_q;
  logic [DATA_W-1:0] sp_q, sp_d;
  logic [BankW-1:0]  bank_q, bank_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              sp_wr;

  // Banked writes use bank_q, i.e. the bank active in the write cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < int'(NUM_BANKS); b++) begin
        for (int r = 0; r < 8; r++) begin
          gpr_q[b][r] <= '0;
        end
      end
      for (int s = 0; s < 4; s++) begin
        scratch_q[s] <= '0;
      end
      isr_q <= '0;
    end else if (write_en) begin
      if (!write_addr[3]) begin
        gpr_q[bank_q][write_addr[2:0]] <= write_data;
      end else if (!write_addr[2]) begin
        scratch_q[write_addr[1:0]] <= write_data;
      end else if (write_addr[1:0] == 2'b00) begin
        isr_q <= write_data;
      end
    end
  end

  always_comb begin
    sp_d  = sp_q;
    sp_wr = write_en && (write_addr == 4'hD);
    if (sp_wr) begin
      sp_d = write_data;
    end else if (sp_inc && !sp_dec) begin
      sp_d = sp_q + SpStride;
    end else if (sp_dec && !sp_inc) begin
      sp_d = sp_q - SpStride;
    end
  end

  always_comb begin
    bank_d = bank_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    if (irq_enter && !irq_exit) begin
      if (bank_q == TopBank) begin
        ovf_d = 1'b1;
      end else begin
        bank_d = bank_q + 1'b1;
      end
    end else if (irq_exit && !irq_enter) begin
      if (bank_q == '0) begin
        unf_d = 1'b1;
      end else begin
        bank_d = bank_q - 1'b1;
      end
    end
    if (flag_clear) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sp_q   <= SpReset;
      bank_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      sp_q   <= sp_d;
      bank_q <= bank_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  always_comb begin
    logic [3:0]        ra;
    logic [DATA_W-1:0] rv;
    read_data = '0;
    for (int i = 0; i < int'(READ_PORTS); i++) begin
      ra = read_addr[4*i +: 4];
      rv = '0;
      if (!ra[3]) begin
        rv = gpr_q[bank_q][ra[2:0]];
      end else if (!ra[2]) begin
        rv = scratch_q[ra[1:0]];
      end else begin
        case (ra[1:0])
          2'b00:   rv = isr_q;
          2'b01:   rv = sp_q;
          2'b10:   rv = SR;
          default: rv = PC;
        endcase
      end
      // A write to D always wins SP priority, so only E/F need excluding here.
      if (BYPASS && write_en && (ra == write_addr) && (ra[3:1] != 3'b111)) begin
        rv = write_data;
      end
      read_data[DATA_W*i +: DATA_W] = rv;
    end
  end

  assign sp             = sp_q;
  assign active_bank    = bank_q;
  assign bank_overflow  = ovf_q;
  assign bank_underflow = unf_q;

endmodule

// File: tb/tb_banked_regfile.sv
// Scoreboard bench for banked_regfile: stimulus queues expectations, a negedge monitor drains them.
module tb_banked_regfile;

  logic        clock;
  logic        reset;
  logic [11:0] read_addr;
  logic [47:0] read_data0, read_data1;
  logic [3:0]  write_addr;
  logic [15:0] write_data;
  logic        write_en, sp_inc, sp_dec, irq_enter, irq_exit, flag_clear;
  logic [15:0] SR, PC;
  logic [15:0] sp0, sp1;
  logic        bank0, bank1;
  logic        ovf0, ovf1, unf0, unf1;

  banked_regfile #(.BYPASS(1'b1)) dut (
    .clock(clock), .reset(reset), .read_addr(read_addr), .read_data(read_data0),
    .write_addr(write_addr), .write_data(write_data), .write_en(write_en),
    .sp_inc(sp_inc), .sp_dec(sp_dec), .irq_enter(irq_enter), .irq_exit(irq_exit),
    .SR(SR), .PC(PC), .sp(sp0), .active_bank(bank0), .bank_overflow(ovf0),
    .bank_underflow(unf0), .flag_clear(flag_clear)
  );

  banked_regfile #(.BYPASS(1'b0)) dut_nobyp (
    .clock(clock), .reset(reset), .read_addr(read_addr), .read_data(read_data1),
    .write_addr(write_addr), .write_data(write_data), .write_en(write_en),
    .sp_inc(sp_inc), .sp_dec(sp_dec), .irq_enter(irq_enter), .irq_exit(irq_exit),
    .SR(SR), .PC(PC), .sp(sp1), .active_bank(bank1), .bank_overflow(ovf1),
    .bank_underflow(unf1), .flag_clear(flag_clear)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef enum int {KRd0, KRd1, KSp, KBank, KOvf, KUnf} kind_e;
  typedef struct {
    kind_e       kind;
    int          idx;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  initial begin
    exp_t        e;
    logic [15:0] act;
    forever begin
      @(negedge clock);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.kind)
          KRd0:    act = read_data0[16*e.idx +: 16];
          KRd1:    act = read_data1[16*e.idx +: 16];
          KSp:     act = sp0;
          KBank:   act = 16'(bank0);
          KOvf:    act = 16'(ovf0);
          default: act = 16'(unf0);
        endcase
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic expect_val(input kind_e k, input int idx, input logic [15:0] v, input string n);
    exp_t e;
    e.kind = k;
    e.idx  = idx;
    e.exp  = v;
    e.name = n;
    sb.push_back(e);
  endtask

  // Set port p to address a and queue the value expected from the forwarding instance.
  task automatic rd(input int p, input logic [3:0] a, input logic [15:0] v, input string n);
    read_addr[4*p +: 4] = a;
    expect_val(KRd0, p, v, n);
  endtask

  task automatic rd1(input int p, input logic [15:0] v, input string n);
    expect_val(KRd1, p, v, n);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    write_en   = 1'b0;
    sp_inc     = 1'b0;
    sp_dec     = 1'b0;
    irq_enter  = 1'b0;
    irq_exit   = 1'b0;
    flag_clear = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    write_en   = 1'b1;
    write_addr = a;
    write_data = d;
  endtask

  task automatic flags(input logic [15:0] b, input logic [15:0] o, input logic [15:0] u,
                       input string n);
    expect_val(KBank, 0, b, {n, "_bank"});
    expect_val(KOvf, 0, o, {n, "_ovf"});
    expect_val(KUnf, 0, u, {n, "_unf"});
  endtask

  initial begin
    reset      = 1'b0;
    read_addr  = '0;
    write_addr = '0;
    write_data = '0;
    SR         = 16'h5A5A;
    PC         = 16'h1234;
    idle();
    repeat (2) tick();
    reset = 1'b1;

    // Reset state and address map.
    expect_val(KSp, 0, 16'hBFFF, "reset_sp");
    flags(0, 0, 0, "reset");
    for (int a = 0; a <= 12; a++) begin
      rd(0, 4'(a), 16'h0000, $sformatf("reset_r%0h", a));
      rd(1, 4'hE, 16'h5A5A, "read_sr");
      rd(2, 4'hF, 16'h1234, "read_pc");
      tick();
    end

    // Bank isolation.
    wr(4'h3, 16'h1111); tick(); idle();
    irq_enter = 1'b1; tick(); idle();
    wr(4'h3, 16'h2222); tick();
    wr(4'h9, 16'h5555); tick(); idle();
    rd(0, 4'h3, 16'h2222, "bank1_r3");
    rd(1, 4'h9, 16'h5555, "bank1_r9");
    expect_val(KBank, 0, 16'h0001, "bank1_active");
    tick();
    irq_exit = 1'b1; tick(); idle();
    rd(0, 4'h3, 16'h1111, "bank0_r3");
    rd(1, 4'h9, 16'h5555, "bank0_r9");
    expect_val(KBank, 0, 16'h0000, "bank0_active");
    tick();

    // Banked write lands in the old bank when a switch commits at the same edge.
    wr(4'h4, 16'h7777); irq_enter = 1'b1; tick(); idle();
    rd(0, 4'h4, 16'h0000, "switch_wr_bank1_r4");
    tick();
    irq_exit = 1'b1; tick(); idle();
    rd(0, 4'h4, 16'h7777, "switch_wr_bank0_r4");
    tick();

    // Overflow / underflow / clear.
    irq_enter = 1'b1; tick(); tick(); idle();
    flags(1, 1, 0, "overflow");
    tick();
    irq_exit = 1'b1; tick(); tick(); idle();
    flags(0, 1, 1, "underflow");
    tick();
    flag_clear = 1'b1; irq_exit = 1'b1; tick(); idle();
    flags(0, 0, 0, "clear_wins");
    tick();
    irq_enter = 1'b1; irq_exit = 1'b1; tick(); idle();
    flags(0, 0, 0, "enter_exit_same");
    tick();

    // SP priority and wrap.
    sp_dec = 1'b1; repeat (3) tick(); idle();
    expect_val(KSp, 0, 16'hBFFC, "sp_dec3");
    rd(2, 4'hD, 16'hBFFC, "read_sp");
    tick();
    wr(4'hD, 16'h0000); sp_inc = 1'b1; tick(); idle();
    expect_val(KSp, 0, 16'h0000, "sp_write_wins");
    tick();
    sp_dec = 1'b1; tick(); idle();
    expect_val(KSp, 0, 16'hFFFF, "sp_wrap");
    tick();
    sp_inc = 1'b1; sp_dec = 1'b1; tick(); idle();
    expect_val(KSp, 0, 16'hFFFF, "sp_inc_dec");
    tick();

    // Forwarding versus registered-only reads.
    wr(4'h5, 16'hABCD);
    rd(2, 4'h5, 16'hABCD, "bypass_r5");
    rd1(2, 16'h0000, "nobypass_r5_old");
    tick(); idle();
    rd(2, 4'h5, 16'hABCD, "bypass_r5_next");
    rd1(2, 16'hABCD, "nobypass_r5_next");
    tick();
    wr(4'hD, 16'h1234); sp_dec = 1'b1;
    rd(0, 4'hD, 16'h1234, "bypass_sp");
    rd1(0, 16'hFFFF, "nobypass_sp_old");
    tick(); idle();
    expect_val(KSp, 0, 16'h1234, "sp_after_write");
    wr(4'hE, 16'h9999);
    rd(1, 4'hE, 16'h5A5A, "sr_write_dropped");
    tick(); idle();

    // Asynchronous reset while in bank 1.
    irq_enter = 1'b1; tick(); idle();
    rd(0, 4'h3, 16'h2222, "isr_r3");
    expect_val(KBank, 0, 16'h0001, "isr_bank");
    expect_val(KSp, 0, 16'h1234, "isr_sp");
    tick();
    reset = 1'b0;
    #2;
    expect_val(KBank, 0, 16'h0000, "async_bank");
    expect_val(KSp, 0, 16'hBFFF, "async_sp");
    rd(0, 4'h3, 16'h0000, "async_r3");
    tick();
    reset = 1'b1;
    tick();

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
